// File: rtl/gps_ca_acquire.sv
// GPS C/A code phase acquisition: regenerates a PRN's Gold code and searches all 1023 phases
// for the 13-chip input word. Optional GPS_ACQ_AMBIG_EN runs the full period and flags repeats.
module gps_ca_acquire #(
  parameter int unsigned CHIP_W  = 13,
  parameter int unsigned MAX_ERR = 0
) (
  input  logic              sys_clk_50,
  input  logic              sync_rst_in,
  input  logic              start,
  input  logic [5:0]        sv_num,
  input  logic [CHIP_W-1:0] ca_code,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic              invalid,
  output logic [9:0]        code_phase,
  output logic [3:0]        err_bits,
  output logic              ambig
);

  typedef enum logic [1:0] {StIdle, StLoad, StSearch, StDone} state_e;

  localparam logic [3:0]  MaxErr   = 4'(MAX_ERR);
  localparam logic [10:0] LastK    = 11'd1034;
  localparam logic [10:0] FirstCmp = 11'(CHIP_W - 1);

  state_e            state_q, state_d;
  logic [5:0]        sv_q, sv_d;
  logic [CHIP_W-1:0] word_q, word_d;
  logic [CHIP_W-1:0] win_q, win_d;
  logic [9:0]        g1_q, g1_d;
  logic [9:0]        g2_q, g2_d;
  logic [10:0]       k_q, k_d;
  logic              found_q, found_d;
  logic              invalid_q, invalid_d;
  logic [9:0]        phase_q, phase_d;
  logic [3:0]        err_q, err_d;
  logic              ambig_q, ambig_d;

  logic              g2_tap;
  logic              chip;
  logic [CHIP_W-1:0] win_next;
  logic [CHIP_W-1:0] diff;
  logic [3:0]        err;
  logic              hit;

  // G2 output taps (stage n held in bit n-1)
  always_comb begin
    g2_tap = 1'b0;
    case (sv_q)
      6'd1:  g2_tap = g2_q[1] ^ g2_q[5];
      6'd2:  g2_tap = g2_q[2] ^ g2_q[6];
      6'd3:  g2_tap = g2_q[3] ^ g2_q[7];
      6'd4:  g2_tap = g2_q[4] ^ g2_q[8];
      6'd5:  g2_tap = g2_q[0] ^ g2_q[8];
      6'd6:  g2_tap = g2_q[1] ^ g2_q[9];
      6'd7:  g2_tap = g2_q[0] ^ g2_q[7];
      6'd8:  g2_tap = g2_q[1] ^ g2_q[8];
      6'd9:  g2_tap = g2_q[2] ^ g2_q[9];
      6'd10: g2_tap = g2_q[1] ^ g2_q[2];
      6'd11: g2_tap = g2_q[2] ^ g2_q[3];
      6'd12: g2_tap = g2_q[4] ^ g2_q[5];
      6'd13: g2_tap = g2_q[5] ^ g2_q[6];
      6'd14: g2_tap = g2_q[6] ^ g2_q[7];
      6'd15: g2_tap = g2_q[7] ^ g2_q[8];
      6'd16: g2_tap = g2_q[8] ^ g2_q[9];
      6'd17: g2_tap = g2_q[0] ^ g2_q[3];
      6'd18: g2_tap = g2_q[1] ^ g2_q[4];
      6'd19: g2_tap = g2_q[2] ^ g2_q[5];
      6'd20: g2_tap = g2_q[3] ^ g2_q[6];
      6'd21: g2_tap = g2_q[4] ^ g2_q[7];
      6'd22: g2_tap = g2_q[5] ^ g2_q[8];
      6'd23: g2_tap = g2_q[0] ^ g2_q[2];
      6'd24: g2_tap = g2_q[3] ^ g2_q[5];
      6'd25: g2_tap = g2_q[4] ^ g2_q[6];
      6'd26: g2_tap = g2_q[5] ^ g2_q[7];
      6'd27: g2_tap = g2_q[6] ^ g2_q[8];
      6'd28: g2_tap = g2_q[7] ^ g2_q[9];
      6'd29: g2_tap = g2_q[0] ^ g2_q[5];
      6'd30: g2_tap = g2_q[1] ^ g2_q[6];
      6'd31: g2_tap = g2_q[2] ^ g2_q[7];
      6'd32: g2_tap = g2_q[3] ^ g2_q[8];
      default: g2_tap = 1'b0;
    endcase
  end

  always_comb begin
    chip     = g1_q[9] ^ g2_tap;
    win_next = {win_q[CHIP_W-2:0], chip};
    diff     = win_next ^ word_q;
    err      = '0;
    for (int i = 0; i < int'(CHIP_W); i++) begin
      err = err + 4'(diff[i]);
    end
    hit = (k_q >= FirstCmp) && (err <= MaxErr);
  end

  always_comb begin
    state_d   = state_q;
    sv_d      = sv_q;
    word_d    = word_q;
    win_d     = win_q;
    g1_d      = g1_q;
    g2_d      = g2_q;
    k_d       = k_q;
    found_d   = found_q;
    invalid_d = invalid_q;
    phase_d   = phase_q;
    err_d     = err_q;
    ambig_d   = ambig_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          sv_d      = sv_num;
          word_d    = ca_code;
          found_d   = 1'b0;
          invalid_d = 1'b0;
          phase_d   = '0;
          err_d     = '0;
          ambig_d   = 1'b0;
          state_d   = StLoad;
        end
      end
      StLoad: begin
        if (sv_q == 6'd0 || sv_q > 6'd32) begin
          invalid_d = 1'b1;
          state_d   = StDone;
        end else begin
          g1_d    = '1;
          g2_d    = '1;
          k_d     = '0;
          win_d   = '0;
          state_d = StSearch;
        end
      end
      StSearch: begin
        win_d = win_next;
        g1_d  = {g1_q[8:0], g1_q[2] ^ g1_q[9]};
        g2_d  = {g2_q[8:0], g2_q[1] ^ g2_q[2] ^ g2_q[5] ^ g2_q[7] ^ g2_q[8] ^ g2_q[9]};
        k_d   = k_q + 11'd1;
        if (hit && !found_q) begin
          found_d = 1'b1;
          // k never exceeds 1034, so the low 10 bits give k-12 without wrap
          phase_d = k_q[9:0] - 10'(CHIP_W - 1);
          err_d   = err;
`ifndef GPS_ACQ_AMBIG_EN
          state_d = StDone;
`endif
        end
`ifdef GPS_ACQ_AMBIG_EN
        else if (hit) begin
          ambig_d = 1'b1;
        end
`endif
        if (k_q == LastK) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge sys_clk_50) begin
    if (sync_rst_in) begin
      state_q   <= StIdle;
      sv_q      <= '0;
      word_q    <= '0;
      win_q     <= '0;
      g1_q      <= '1;
      g2_q      <= '1;
      k_q       <= '0;
      found_q   <= 1'b0;
      invalid_q <= 1'b0;
      phase_q   <= '0;
      err_q     <= '0;
      ambig_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      sv_q      <= sv_d;
      word_q    <= word_d;
      win_q     <= win_d;
      g1_q      <= g1_d;
      g2_q      <= g2_d;
      k_q       <= k_d;
      found_q   <= found_d;
      invalid_q <= invalid_d;
      phase_q   <= phase_d;
      err_q     <= err_d;
      ambig_q   <= ambig_d;
    end
  end

  assign busy       = (state_q == StLoad) || (state_q == StSearch);
  assign done       = (state_q == StDone);
  assign found      = found_q;
  assign invalid    = invalid_q;
  assign code_phase = phase_q;
  assign err_bits   = err_q;
`ifdef GPS_ACQ_AMBIG_EN
  assign ambig      = ambig_q;
`else
  assign ambig      = 1'b0;
`endif

endmodule

// File: tb/tb_gps_ca_acquire.sv
// Self-checking bench for gps_ca_acquire: three instances (MAX_ERR 0/1/3) checked against a
// behavioural Gold-code model; honours GPS_ACQ_AMBIG_EN when defined for both files.
module tb_gps_ca_acquire;

`ifdef GPS_ACQ_AMBIG_EN
  localparam bit AmbigEn = 1'b1;
`else
  localparam bit AmbigEn = 1'b0;
`endif

  logic        clk;
  logic        sync_rst;
  logic        start_v   [3];
  logic [5:0]  sv_num;
  logic [12:0] ca_code;
  logic        busy_w    [3];
  logic        done_w    [3];
  logic        found_w   [3];
  logic        invalid_w [3];
  logic [9:0]  phase_w   [3];
  logic [3:0]  err_w     [3];
  logic        ambig_w   [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    gps_ca_acquire #(
      .CHIP_W (13),
      .MAX_ERR((g == 0) ? 0 : (g == 1) ? 1 : 3)
    ) u_dut (
      .sys_clk_50 (clk),
      .sync_rst_in(sync_rst),
      .start      (start_v[g]),
      .sv_num     (sv_num),
      .ca_code    (ca_code),
      .busy       (busy_w[g]),
      .done       (done_w[g]),
      .found      (found_w[g]),
      .invalid    (invalid_w[g]),
      .code_phase (phase_w[g]),
      .err_bits   (err_w[g]),
      .ambig      (ambig_w[g])
    );
  end

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit prn [1:32][0:1022];

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int max_err_of(input int i);
    return (i == 0) ? 0 : (i == 1) ? 1 : 3;
  endfunction

  task automatic gen_prn();
    int ta [32] = '{2,3,4,5,1,2,1,2,3,2,3,5,6,7,8,9,1,2,3,4,5,6,1,4,5,6,7,8,1,2,3,4};
    int tb [32] = '{6,7,8,9,9,10,8,9,10,3,4,6,7,8,9,10,4,5,6,7,8,9,3,6,7,8,9,10,6,7,8,9};
    bit s1 [1:10];
    bit s2 [1:10];
    bit f1, f2;
    for (int sv = 1; sv <= 32; sv++) begin
      for (int i = 1; i <= 10; i++) begin
        s1[i] = 1'b1;
        s2[i] = 1'b1;
      end
      for (int c = 0; c < 1023; c++) begin
        prn[sv][c] = s1[10] ^ s2[ta[sv-1]] ^ s2[tb[sv-1]];
        f1 = s1[3] ^ s1[10];
        f2 = s2[2] ^ s2[3] ^ s2[6] ^ s2[8] ^ s2[9] ^ s2[10];
        for (int j = 10; j >= 2; j--) begin
          s1[j] = s1[j-1];
          s2[j] = s2[j-1];
        end
        s1[1] = f1;
        s2[1] = f2;
      end
    end
  endtask

  function automatic logic [12:0] mk_word(input int sv, input int p);
    logic [12:0] w;
    for (int j = 0; j < 13; j++) w[12-j] = prn[sv][(p + j) % 1023];
    return w;
  endfunction

  task automatic model(input int max_err, input int sv, input logic [12:0] word,
                       output int e_found, output int e_inv, output int e_phase,
                       output int e_err, output int e_ambig, output int e_lat);
    int cnt = 0;
    int e;
    e_found = 0; e_inv = 0; e_phase = 0; e_err = 0; e_ambig = 0;
    if (sv < 1 || sv > 32) begin
      e_inv = 1;
      e_lat = 2;
      return;
    end
    for (int p = 0; p < 1023; p++) begin
      e = $countones(mk_word(sv, p) ^ word);
      if (e <= max_err) begin
        cnt++;
        if (cnt == 1) begin
          e_found = 1;
          e_phase = p;
          e_err   = e;
        end
      end
    end
    e_ambig = (AmbigEn && cnt > 1) ? 1 : 0;
    e_lat   = (e_found == 1 && !AmbigEn) ? e_phase + 15 : 1037;
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s/d%0d/busy", tag, i), 32'(busy_w[i]), 0);
      check($sformatf("%s/d%0d/done", tag, i), 32'(done_w[i]), 0);
      check($sformatf("%s/d%0d/found", tag, i), 32'(found_w[i]), 0);
      check($sformatf("%s/d%0d/invalid", tag, i), 32'(invalid_w[i]), 0);
      check($sformatf("%s/d%0d/phase", tag, i), 32'(phase_w[i]), 0);
      check($sformatf("%s/d%0d/err", tag, i), 32'(err_w[i]), 0);
      check($sformatf("%s/d%0d/ambig", tag, i), 32'(ambig_w[i]), 0);
    end
  endtask

  // Start all three instances together at cycle 0 and check each against the model.
  task automatic do_search(input string tag, input int sv, input logic [12:0] word);
    int ef [3], ei [3], ep [3], ee [3], ea [3], el [3];
    int got_lat [3], dn [3], bc [3];
    int max_lat = 0;
    for (int i = 0; i < 3; i++) begin
      model(max_err_of(i), sv, word, ef[i], ei[i], ep[i], ee[i], ea[i], el[i]);
      if (el[i] > max_lat) max_lat = el[i];
      got_lat[i] = 0; dn[i] = 0; bc[i] = 0;
    end
    @(negedge clk);
    sv_num = 6'(sv); ca_code = word;
    for (int i = 0; i < 3; i++) start_v[i] = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) start_v[i] = 1'b0;
    sv_num = 6'($urandom); ca_code = 13'($urandom);
    for (int n = 1; n <= max_lat + 1; n++) begin
      for (int i = 0; i < 3; i++) begin
        if (busy_w[i]) bc[i]++;
        if (done_w[i]) begin
          dn[i]++;
          if (dn[i] == 1) got_lat[i] = n;
        end
      end
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s/d%0d/lat", tag, i), got_lat[i], el[i]);
      check($sformatf("%s/d%0d/ndone", tag, i), dn[i], 1);
      check($sformatf("%s/d%0d/busycyc", tag, i), bc[i], el[i] - 1);
      check($sformatf("%s/d%0d/found", tag, i), 32'(found_w[i]), ef[i]);
      check($sformatf("%s/d%0d/invalid", tag, i), 32'(invalid_w[i]), ei[i]);
      check($sformatf("%s/d%0d/phase", tag, i), 32'(phase_w[i]), ep[i]);
      check($sformatf("%s/d%0d/err", tag, i), 32'(err_w[i]), ee[i]);
      check($sformatf("%s/d%0d/ambig", tag, i), 32'(ambig_w[i]), ea[i]);
    end
  endtask

  // Instance 0 only: extra starts mid-search and in the done cycle must be ignored.
  task automatic ignored_start_test(input logic [12:0] word);
    int ef, ei, ep, ee, ea, el;
    int got = 0, dn = 0, bc = 0;
    model(0, 2, word, ef, ei, ep, ee, ea, el);
    @(negedge clk);
    sv_num = 6'd2; ca_code = word; start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    for (int n = 1; n <= el + 2; n++) begin
      if (busy_w[0]) bc++;
      if (done_w[0]) begin
        dn++;
        if (dn == 1) got = n;
      end
      if ((n == 100 && el > 101) || n == el) begin
        start_v[0] = 1'b1; sv_num = 6'd5; ca_code = ~word;
      end else begin
        start_v[0] = 1'b0;
      end
      @(negedge clk);
    end
    start_v[0] = 1'b0;
    check("ign/lat", got, el);
    check("ign/ndone", dn, 1);
    check("ign/busycyc", bc, el - 1);
    check("ign/found", 32'(found_w[0]), ef);
    check("ign/phase", 32'(phase_w[0]), ep);
    check("ign/err", 32'(err_w[0]), ee);
  endtask

  task automatic reset_abort_test(input logic [12:0] word);
    int ef, ei, ep, ee, ea, el;
    int dn = 0;
    model(0, 2, word, ef, ei, ep, ee, ea, el);
    @(negedge clk);
    sv_num = 6'd2; ca_code = word; start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    for (int n = 1; n <= 1100; n++) begin
      if (done_w[0]) dn++;
      start_v[0] = (n == 100 && el > 101);
      if (n == 100) begin
        sv_num = 6'd7; ca_code = ~word;
      end
      sync_rst = (n == 400);
      @(negedge clk);
      if (n == 400) check_reset_outputs("rstmid");
    end
    sync_rst   = 1'b0;
    start_v[0] = 1'b0;
    check("rstmid/ndone", dn, (el <= 400) ? 1 : 0);
  endtask

  initial begin
    gen_prn();
    sync_rst = 1'b1;
    for (int i = 0; i < 3; i++) start_v[i] = 1'b0;
    sv_num  = '0;
    ca_code = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    sync_rst = 1'b0;

    do_search("prn1_p0", 1, mk_word(1, 0));
    do_search("prn12_p500", 12, mk_word(12, 500));
    do_search("prn12_p1020", 12, mk_word(12, 1020));
    do_search("prn1_p300_flip", 1, mk_word(1, 300) ^ 13'h0020);
    do_search("sv0", 0, 13'h0ABC);
    do_search("sv33", 33, 13'h1234);
    ignored_start_test(mk_word(2, 600));
    reset_abort_test(mk_word(2, 800));
    do_search("after_rst", 2, mk_word(2, 800));
    do_search("prn3_ones", 3, 13'h1FFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
